// File: rtl/aesl_deadlock_idx0_monitor_pkg.sv
// Shared defaults and widths for the deadlock/stall monitor.
package aesl_deadlock_idx0_monitor_pkg;

   localparam int DEF_AXIS_N       = 4;
   localparam int DEF_IDLE_N       = 3;
   localparam int DEF_IBLK_N       = 1;
   localparam int DEF_STALL_CYCLES = 4;
   localparam int CNT_W            = 16;

endpackage

// File: rtl/aesl_stall_counter.sv
// Tracks how long a stuck input pattern has stayed unchanged.
// thresh reflects the count being loaded at the coming edge, so the
// parent can register it and have block rise on the same edge the
// count reaches the threshold.
module aesl_stall_counter
   import aesl_deadlock_idx0_monitor_pkg::*;
#(
   parameter int SIG_W        = DEF_AXIS_N + DEF_IDLE_N + DEF_IBLK_N,
   parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stuck,
   input  logic [SIG_W-1:0] sigs,
   output logic             thresh
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_CYCLES);

   logic [SIG_W-1:0] snap_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_next;
   logic             same;

   // Next count: saturating increment on an unchanged stuck pattern,
   // otherwise restart at 1 (stuck) or 0 (not stuck).
   always_comb begin
      same = (sigs == snap_q);
      cnt_next = '0;
      if (stuck && same) begin
         if (cnt_q >= CNT_MAX) cnt_next = CNT_MAX;
         else                  cnt_next = cnt_q + 1'b1;
      end else if (stuck) begin
         cnt_next = CNT_W'(1);
      end
      thresh = (cnt_next >= CNT_MAX);
   end

   // Count and snapshot registers; snapshot only reloads on a restart.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         snap_q <= '0;
      end else begin
         cnt_q <= cnt_next;
         if (!(stuck && same)) snap_q <= sigs;
      end
   end

endmodule

// File: rtl/aesl_deadlock_idx0_monitor.sv
// Kernel deadlock/stall monitor: flags a stuck block/idle pattern that
// has held unchanged for STALL_CYCLES consecutive cycles.
module aesl_deadlock_idx0_monitor
   import aesl_deadlock_idx0_monitor_pkg::*;
#(
   parameter int AXIS_N       = DEF_AXIS_N,
   parameter int IDLE_N       = DEF_IDLE_N,
   parameter int IBLK_N       = DEF_IBLK_N,
   parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [AXIS_N-1:0] axis_block_sigs,
   input  logic [IDLE_N-1:0] inst_idle_sigs,
   input  logic [IBLK_N-1:0] inst_block_sigs,
   output logic              block
);

   localparam int SIG_W = AXIS_N + IDLE_N + IBLK_N;

   logic             stuck;
   logic             thresh;
   logic [SIG_W-1:0] sigs;

   // Something is waiting while not everything is idle.
   always_comb begin
      stuck = ((|axis_block_sigs) || (|inst_block_sigs)) && !(&inst_idle_sigs);
      sigs  = {axis_block_sigs, inst_idle_sigs, inst_block_sigs};
   end

   aesl_stall_counter #(
      .SIG_W        (SIG_W),
      .STALL_CYCLES (STALL_CYCLES)
   ) u_stall_counter (
      .clock  (clock),
      .reset  (reset),
      .stuck  (stuck),
      .sigs   (sigs),
      .thresh (thresh)
   );

   // Registered output keeps inputs off any combinational path to block.
   always_ff @(posedge clock) begin
      if (reset) block <= 1'b0;
      else       block <= thresh;
   end

endmodule

// File: tb/tb_aesl_deadlock_idx0_monitor.sv
// Directed bench for the deadlock/stall monitor (STALL_CYCLES = 4).
module tb_aesl_deadlock_idx0_monitor;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] axis_block_sigs = '0;
   logic [2:0] inst_idle_sigs  = '0;
   logic [0:0] inst_block_sigs = '0;
   logic       block;

   int n_checks = 0;
   int n_errors = 0;

   aesl_deadlock_idx0_monitor dut (
      .clock           (clock),
      .reset           (reset),
      .axis_block_sigs (axis_block_sigs),
      .inst_idle_sigs  (inst_idle_sigs),
      .inst_block_sigs (inst_block_sigs),
      .block           (block)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: block=%b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge, then settle before sampling/driving.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1;
      // reset for 3 edges, inputs present but ignored
      axis_block_sigs = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset", block, 1'b0);
      end
      reset = 1'b0;

      // stable stuck pattern: 0 for edges 1..3, 1 from edge 4
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("stable_e%0d", i), block, (i >= 4));
      end

      // pattern change while saturated: drops next edge, back at 4th
      axis_block_sigs = 4'b1000;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("change_e%0d", i), block, (i >= 4));
      end

      // stuck falls (all idle): drops next edge
      inst_idle_sigs = 3'b111;
      tick();
      chk("stuck_fall", block, 1'b0);
      inst_idle_sigs = 3'b000;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("restuck_e%0d", i), block, (i >= 4));
      end

      // idle-flag change on a still-stuck pattern restarts the count
      inst_idle_sigs = 3'b001;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("idlechg_e%0d", i), block, (i >= 4));
      end

      // all idle never blocks
      axis_block_sigs = 4'b1111;
      inst_idle_sigs  = 3'b111;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("all_idle", block, 1'b0);
      end

      // no block flags never blocks
      axis_block_sigs = 4'b0000;
      inst_idle_sigs  = 3'b010;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("no_flags", block, 1'b0);
      end

      // instance block flag; reset pulse at edge 6
      inst_idle_sigs  = 3'b000;
      inst_block_sigs = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("iblk_e%0d", i), block, (i >= 4));
      end
      reset = 1'b1;
      tick();
      chk("iblk_reset", block, 1'b0);
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("iblk_rel_e%0d", i), block, (i >= 4));
      end

      // toggling pattern every 2 cycles never blocks
      inst_block_sigs = 1'b0;
      for (int i = 0; i < 24; i++) begin
         axis_block_sigs = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0010;
         tick();
         chk("toggle", block, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/aesl_deadlock_idx0_monitor.md
AESL_DEADLOCK_IDX0_MONITOR -- requirements
Module: aesl_deadlock_idx0_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - AXIS_N, 4: number of AXI-Stream port block flags.
  - IDLE_N, 3: number of instance idle flags.
  - IBLK_N, 1: number of instance block flags.
  - STALL_CYCLES, 4: consecutive stuck cycles before block asserts (legal range 1..65535).
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clock, input, 1: single clock, rising edge.
  - reset, input, 1: synchronous, active-high.
  - axis_block_sigs, input, AXIS_N: bit i = 1 means stream port i is waiting on the outside world (no input data / output not ready).
  - inst_idle_sigs, input, IDLE_N: bit i = 1 means sub-instance i is idle; bit 0 is the top FSM.
  - inst_block_sigs, input, IBLK_N: bit i = 1 means an internal channel of instance i is blocked.
  - block, output, 1: kernel deadlock/stall detected.
REQ-003 The design has one clock and one reset: reset is synchronous and active-high; ports are named clock and reset.

Function
REQ-004 Combinational condition: stuck = (|axis_block_sigs OR |inst_block_sigs) AND NOT (&inst_idle_sigs).
REQ-005 The design holds a registered snapshot of {axis_block_sigs, inst_idle_sigs, inst_block_sigs}, width AXIS_N+IDLE_N+IBLK_N.
REQ-006 Stall counter: 16-bit, saturating at STALL_CYCLES.
REQ-007 Each cycle, if stuck=1 and inputs equal the snapshot, the counter increments (saturating).
REQ-008 Otherwise the counter loads 1 if stuck=1, or 0 if stuck=0, and the snapshot loads the current inputs.
REQ-009 block is registered and equals (counter reaches STALL_CYCLES) on the next edge.
  - With a stable stuck pattern starting at edge N, block rises after edge N+STALL_CYCLES.
REQ-010 block deasserts one cycle after stuck falls or any input bit changes.
  - It does not re-assert until STALL_CYCLES further stable stuck cycles have elapsed.
REQ-011 All inputs idle (&inst_idle_sigs = 1) never causes block, regardless of the block flags.
REQ-012 Block flags all 0 never causes block, regardless of the idle flags.
REQ-013 While the counter is saturated, an input change takes precedence over the increment (REQ-008 applies).
REQ-014 X/Z on inputs is not handled; inputs are assumed driven from reset release.

Reset
REQ-015 While reset=1 at a clock edge:
  - block=0, counter=0, snapshot=0.
  - Inputs are ignored.
REQ-016 Reset asserted mid-stall clears block on that edge.
  - Detection restarts from zero after reset release.

Structure
REQ-017 A shared package holds:
  - the default constants AXIS_N, IDLE_N, IBLK_N, STALL_CYCLES;
  - the counter width (16).
REQ-018 One sub-module, aesl_stall_counter, implements:
  - the snapshot compare;
  - the saturating counter;
  - the threshold flag.
REQ-019 The top level computes stuck and registers block.
REQ-020 The design contains no latches and no combinational path from the inputs to block.

Verification
REQ-021 Scenario: reset high for 3 cycles, then release, axis_block_sigs=4'b0001, inst_idle_sigs=3'b000, inst_block_sigs=0, held constant.
  - block=0 for the first 3 edges after release.
  - block=1 from the 4th edge onward (STALL_CYCLES=4).
REQ-022 Scenario: after block=1, change axis_block_sigs to 4'b1000.
  - block=0 on the next edge.
  - block=1 again 4 edges after the change.
REQ-023 Scenario: inst_idle_sigs=3'b111 with axis_block_sigs=4'b1111 held for 20 cycles.
  - block stays 0.
REQ-024 Scenario: axis_block_sigs=0, inst_block_sigs=0, inst_idle_sigs=3'b010 held for 20 cycles.
  - block stays 0.
REQ-025 Scenario: inst_block_sigs=1 with all other inputs 0; reset pulsed for 1 cycle at cycle 6.
  - block rises at edge 4 and clears on the reset edge.
  - block rises again 4 edges after release.
REQ-026 Scenario: axis_block_sigs toggles 4'b0001/4'b0010 every 2 cycles.
  - block never asserts.
